ee201_pulse_gen_multi: RTL

Multi-channel programmable pulse generator for EE201 lab designs. It replaces the single-channel pulse-at-N divider with CHANNELS independent channels. Each channel has a programmable period N, a programmable high time PW, and a periodic or one-shot mode. It feeds display scanning, debouncer sampling and timed-event logic from the single system clock. Per-channel terminal-count and busy flags let a controlling FSM sequence timed events without its own counters.

---
 rtl/ee201_pulse_gen_multi.sv | 111 +++++++++++
 1 files changed

// File: rtl/ee201_pulse_gen_multi.sv
// rtl/ee201_pulse_gen_multi.sv - multi-channel programmable pulse generator
module ee201_pulse_gen_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [CHANNELS-1:0]       En,
    input  logic [CHANNELS-1:0]       Mode,
    input  logic [CHANNELS-1:0]       Start,
    input  logic [CHANNELS*WIDTH-1:0] N,
    input  logic [CHANNELS*WIDTH-1:0] PW,
    output logic [CHANNELS-1:0]       Pulse,
    output logic [CHANNELS-1:0]       Busy,
    output logic [CHANNELS-1:0]       Tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] nl_q, nl_d;
        logic [WIDTH-1:0] pwl_q, pwl_d;
        logic             pulse_q, pulse_d;
        logic             mode_q, mode_d;
        logic [WIDTH-1:0] n_in, pw_in, cnt_inc;
        logic             last;

        assign n_in    = N[g*WIDTH +: WIDTH];
        assign pw_in   = PW[g*WIDTH +: WIDTH];
        assign cnt_inc = cnt_q + WIDTH'(1);
        // Period boundary: cnt has reached the latched period minus one.
        assign last    = (cnt_q == nl_q - WIDTH'(1));

        // Channel state register; reset clears everything including latched values.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                nl_q    <= '0;
                pwl_q   <= '0;
                pulse_q <= 1'b0;
                mode_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                nl_q    <= nl_d;
                pwl_q   <= pwl_d;
                pulse_q <= pulse_d;
                mode_q  <= mode_d;
            end
        end

        // Next-state: start, period boundary re-latch, one-shot finish, abort.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            nl_d    = nl_q;
            pwl_d   = pwl_q;
            pulse_d = pulse_q;
            mode_d  = mode_q;
            case (state_q)
                IDLE: begin
                    if (En[g] && (!Mode[g] || Start[g]) && (n_in != '0)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        nl_d    = n_in;
                        pwl_d   = pw_in;
                        pulse_d = (pw_in != '0);
                        mode_d  = Mode[g];
                    end
                end
                RUN: begin
                    if (!En[g]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        pulse_d = 1'b0;
                    end else if (last) begin
                        cnt_d = '0;
                        if (mode_q) begin
                            state_d = IDLE;
                            pulse_d = 1'b0;
                        end else begin
                            nl_d  = n_in;
                            pwl_d = pw_in;
                            if (n_in == '0) begin
                                state_d = IDLE;
                                pulse_d = 1'b0;
                            end else begin
                                pulse_d = (pw_in != '0);
                            end
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        pulse_d = (cnt_inc < pwl_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign Pulse[g] = pulse_q;
        assign Busy[g]  = (state_q == RUN);
        assign Tc[g]    = (state_q == RUN) && last;
    end

endmodule
